// File: rtl/restoring_div_16.sv
// Sequential radix-2 restoring divider, signed or unsigned, with start/done handshake.
// Fixed latency: one prep cycle, WIDTH iterations, one sign-fix cycle, one done cycle.
module restoring_div_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             signed_reg, signed_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic [WIDTH:0]   prem_reg, prem_next;    // partial remainder, one guard bit
  logic [WIDTH-1:0] dvd_reg, dvd_next;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_reg, dvs_next;      // divisor magnitude
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             done_reg, done_next;
  logic             dbz_reg, dbz_next;

  // Iteration datapath: shift then trial subtract
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign shifted  = {prem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_reg};
  assign trial_ok = ~trial[WIDTH+1];

  // Magnitude of the most negative value stays as its unsigned bit pattern
  assign mag_a = (signed_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
  assign mag_b = (signed_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign busy        = (state_reg != IDLE);

  // Next-state and datapath updates for every FSM state
  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    signed_next    = signed_reg;
    sign_q_next    = sign_q_reg;
    sign_r_next    = sign_r_reg;
    prem_next      = prem_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    done_next      = 1'b0;
    dbz_next       = dbz_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next      = A;
          b_next      = B;
          signed_next = is_signed;
          dbz_next    = 1'b0;
          state_next  = PREP;
        end
      end
      PREP: begin
        if (b_reg == '0) begin
          quotient_next  = '1;
          remainder_next = a_reg;
          dbz_next       = 1'b1;
          done_next      = 1'b1;
          state_next     = DONE;
        end else begin
          sign_q_next = signed_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          sign_r_next = signed_reg & a_reg[WIDTH-1];
          dvd_next    = mag_a;
          dvs_next    = mag_b;
          prem_next   = '0;
          count_next  = '0;
          state_next  = CALC;
        end
      end
      CALC: begin
        prem_next  = trial_ok ? trial[WIDTH:0] : shifted;
        dvd_next   = {dvd_reg[WIDTH-2:0], trial_ok};
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        quotient_next  = sign_q_reg ? -dvd_reg : dvd_reg;
        remainder_next = sign_r_reg ? -prem_reg[WIDTH-1:0] : prem_reg[WIDTH-1:0];
        done_next      = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      signed_reg    <= 1'b0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      prem_reg      <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      signed_reg    <= signed_next;
      sign_q_reg    <= sign_q_next;
      sign_r_reg    <= sign_r_next;
      prem_reg      <= prem_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      done_reg      <= done_next;
      dbz_reg       <= dbz_next;
    end
  end

endmodule

// File: tb/tb_restoring_div_16.sv
// Self-checking bench for restoring_div_16: directed table, handshake corners, random pairs.
module tb_restoring_div_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [15:0] A, B;
  logic [15:0] quotient, remainder;
  logic        done, busy, div_by_zero;

  int checks = 0;
  int errors = 0;

  restoring_div_16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .quotient(quotient), .remainder(remainder),
    .done(done), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands with start for one edge (E0); returns just after E0
  task automatic launch(input logic s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    is_signed = s; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", busy, 1);
    start = 1'b0;
  endtask

  // Count edges after E0 until done is seen; bounded
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      if (lat >= 40) begin
        check("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input bit full);
    int lat;
    launch(v.s, v.a, v.b);
    wait_done(lat);
    $display("op s=%0d A=%04h B=%04h -> q=%04h r=%04h lat=%0d", v.s, v.a, v.b, quotient, remainder, lat);
    check("quotient", quotient, v.q);
    check("remainder", remainder, v.r);
    if (full) begin
      check("latency", lat, 18);
      check("dbz_clear", div_by_zero, 0);
    end
    @(posedge clk);
    #1;
    if (full) begin
      check("done_pulse_end", done, 0);
      check("busy_end", busy, 0);
    end
  endtask

  function automatic logic [15:0] mag(input logic s, input logic [15:0] x);
    return (s && x[15]) ? -x : x;
  endfunction

  vec_t vecs[10];

  initial begin
    int lat, first_lat, second_lat;
    vec_t v;

    vecs[0] = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2};
    vecs[1] = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE};
    vecs[2] = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'h0002};
    vecs[3] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
    vecs[4] = '{1'b0, 16'hFFFF, 16'd2,    16'h7FFF, 16'h0001};
    vecs[5] = '{1'b0, 16'd5,    16'd9,    16'd0,    16'd5};
    vecs[6] = '{1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF};
    vecs[7] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000};
    vecs[8] = '{1'b1, 16'hFFFF, 16'h8000, 16'h0000, 16'hFFFF};
    vecs[9] = '{1'b1, 16'h7FFF, 16'd1,    16'h7FFF, 16'h0000};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b1);

    // Divide by zero: result at E1, done drops at E2, new start at E3 clears flag
    launch(1'b0, 16'd100, 16'd0);
    wait_done(lat);
    $display("op s=0 A=0064 B=0000 -> q=%04h r=%04h dbz=%0d lat=%0d", quotient, remainder, div_by_zero, lat);
    check("dbz_latency", lat, 1);
    check("dbz_quotient", quotient, 16'hFFFF);
    check("dbz_remainder", remainder, 16'd100);
    check("dbz_flag", div_by_zero, 1);
    @(posedge clk);
    #1;
    check("dbz_done_drop", done, 0);
    check("dbz_busy_drop", busy, 0);
    launch(1'b0, 16'd9, 16'd4);
    check("dbz_cleared_on_start", div_by_zero, 0);
    wait_done(lat);
    $display("op s=0 A=0009 B=0004 -> q=%04h r=%04h lat=%0d", quotient, remainder, lat);
    check("after_dbz_q", quotient, 2);
    check("after_dbz_r", remainder, 1);
    check("after_dbz_lat", lat, 18);
    @(posedge clk);

    // Start pulsed while busy at E5 must be ignored
    launch(1'b0, 16'd1000, 16'd7);
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 4) begin
        start = 1'b1; is_signed = 1'b1; A = 16'hFFFF; B = 16'd1;
      end
      if (lat == 5) start = 1'b0;
      if (done || lat >= 40) break;
    end
    $display("op s=0 A=03e8 B=0007 (start poked at E5) -> q=%04h r=%04h lat=%0d", quotient, remainder, lat);
    check("ignore_start_lat", lat, 18);
    check("ignore_start_q", quotient, 142);
    check("ignore_start_r", remainder, 6);
    @(posedge clk);
    #1;
    check("ignore_start_idle", busy, 0);

    // Back-to-back with start held high: second accepted at E20
    @(negedge clk);
    is_signed = 1'b0; A = 16'd200; B = 16'd9; start = 1'b1;
    @(posedge clk);
    first_lat = -1; second_lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (first_lat < 0) begin
          first_lat = e;
          check("b2b_q1", quotient, 22);
          check("b2b_r1", remainder, 2);
          A = 16'd50; B = 16'd6;
        end else if (second_lat < 0) begin
          second_lat = e;
          check("b2b_q2", quotient, 8);
          check("b2b_r2", remainder, 2);
        end
      end
      if (e == 20) begin
        check("b2b_busy_e20", busy, 1);
        start = 1'b0;
      end
    end
    $display("b2b first_done=%0d second_done=%0d", first_lat, second_lat);
    check("b2b_first_lat", first_lat, 18);
    check("b2b_second_lat", second_lat, 38);

    // Reset asserted at E8 aborts the operation without a done pulse
    launch(1'b0, 16'd300, 16'd7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (done) lat++;
    end
    check("midrst_no_done", lat, 0);
    v = '{1'b1, 16'hFF38, 16'd7, 16'hFFE4, 16'hFFFC};
    run_vec(v, 1'b1);

    // Random pairs against an integer-division model plus identity checks
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb, eq, er, chk;
      logic rs;
      int sa, sb;
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rb == 16'd0) rb = 16'd1;
      if (rs) begin
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        eq = 16'(sa / sb);
        er = 16'(sa % sb);
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      v = '{rs, ra, rb, eq, er};
      run_vec(v, 1'b0);
      chk = quotient * rb + remainder;
      check("identity", chk, ra);
      check("rem_lt_div", (mag(rs, remainder) < mag(rs, rb)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_div_16.md
# restoring_div_16

Sequential restoring divider and the inverse companion of the CPU's 16-bit multiplier. Takes a 16-bit dividend and divisor, signed or unsigned, and produces truncated quotient and remainder after a fixed, data-independent number of cycles. It uses a start/done handshake so the ALU controller can stall on it the same way it stalls on the multiplier. One radix-2 iteration per clock, no combinational divider array.

## Interface
- WIDTH, 16, operand, quotient and remainder width; all timing below is stated for WIDTH=16.
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  in  WIDTH  dividend; sampled with start.
- B  in  WIDTH  divisor; sampled with start.
- quotient  out  WIDTH  registered result; holds its value until the next completion.
- remainder  out  WIDTH  registered result; holds its value until the next completion.
- done  out  1  single-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- div_by_zero  out  1  set with done when B==0; cleared at the next accepted start.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- **IDLE**
  - If start=1: latch A, B and is_signed; clear div_by_zero; go to PREP.
  - Otherwise stay in IDLE.
- **PREP**
  - If the latched B==0: quotient <= all ones, remainder <= latched A, div_by_zero <= 1, done <= 1; go to DONE.
  - Else: record sign_q = is_signed & (A[15]^B[15]) and sign_r = is_signed & A[15].
  - Load magnitudes: |A| and |B| when is_signed, the raw values otherwise.
  - Clear the partial remainder (WIDTH+1 bits, 17 for WIDTH=16) and the counter; go to CALC.
- **CALC**, one iteration per cycle:
  - Shift {partial remainder, dividend register} left by one.
  - Trial = partial remainder − divisor magnitude.
  - If trial ≥ 0: keep the trial and shift in quotient bit 1; else restore and shift in 0.
  - counter increments; after the iteration with counter==WIDTH−1, go to FIX.
- **FIX**
  - quotient <= sign_q ? −q : q.
  - remainder <= sign_r ? −r : r.
  - done <= 1; go to DONE.
- **DONE**: done <= 0; go to IDLE.
- Arithmetic rules:
  - Division truncates toward zero; the remainder takes the dividend's sign. A = quotient·B + remainder holds for every nonzero B.
  - Magnitude of 0x8000 is 0x8000 as an unsigned 16-bit value (no saturation).
  - Signed −32768 / −1 gives quotient 0x8000 (wraps) and remainder 0. No overflow flag.
- start while busy is ignored; it is neither queued nor able to corrupt operands.
- start held high across DONE→IDLE is accepted as a new operation in IDLE.

## Timing
- Reset (next rising edge with reset=1):
  - state=IDLE, quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, counter=0.
  - A reset in the middle of an operation aborts it; no done pulse follows.
- Let start be sampled at edge E0:
  - PREP at edge E1.
  - CALC at edges E2..E17 (16 iterations).
  - FIX at edge E18: quotient, remainder and done update together.
  - DONE at edge E19: done drops, state returns to IDLE.
- Latency: done is high for exactly one cycle, between E18 and E19. Start-to-start throughput is 20 cycles.
- Divide by zero: outputs and done update at E1; done drops at E2; the next start can be accepted at E3.
- busy rises after E0 and falls after E19 (after E2 for divide by zero). It is registered with no combinational path from start.
- quotient and remainder change only at the FIX edge or the PREP divide-by-zero edge, and never glitch during CALC.

## Test plan
- Unsigned: is_signed=0, A=100, B=7 -> quotient=14, remainder=2, done at E18, div_by_zero=0.
- Signed signs: A=−100, B=7 -> quotient=0xFFF2, remainder=0xFFFE. A=100, B=−7 -> quotient=0xFFF2, remainder=0x0002.
- Corners:
  - Signed A=0x8000, B=0xFFFF -> quotient=0x8000, remainder=0.
  - Unsigned A=0xFFFF, B=2 -> quotient=0x7FFF, remainder=1.
  - A=5, B=9 -> quotient=0, remainder=5.
- Divide by zero: A=100, B=0 -> quotient=0xFFFF, remainder=100, div_by_zero=1, done at E1. The following valid start clears div_by_zero.
- Handshake:
  - Pulse start again at E5 with different operands -> ignored; the first result is still correct at E18.
  - Back-to-back requests with start held high -> second start accepted at E20.
- Reset mid-operation: assert reset at E8 -> all outputs 0 and busy=0 next edge, no done. A new start then completes in 18 cycles.
- Randomized: 2000 signed and unsigned pairs, nonzero B, checked against a reference model. Check quotient·B + remainder == A and |remainder| < |B|.
